// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO PHY responder.
package mdio_pkg;

  typedef enum logic [3:0] {
    PRE,
    ST1,
    OP,
    PHYAD,
    REGAD,
    TA,
    RDATA,
    WDATA,
    SKIP
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam logic [4:0] REG_CTRL   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd1;
  localparam logic [4:0] REG_ID1    = 5'd2;
  localparam logic [4:0] REG_ID2    = 5'd3;

  localparam int SOFT_RESET_BIT = 15;

endpackage

// File: rtl/mdio_phy_responder_if.sv
// MDIO pad-side and register-write-notification signals of the PHY responder.
interface mdio_phy_responder_if;

  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic        reg_wr_valid;
  logic [4:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;

  modport master (
    output mdc, mdio_i,
    input  mdio_o, mdio_oe, reg_wr_valid, reg_wr_addr, reg_wr_data
  );

  modport slave (
    input  mdc, mdio_i,
    output mdio_o, mdio_oe, reg_wr_valid, reg_wr_addr, reg_wr_data
  );

endinterface

// File: rtl/mdio_regfile.sv
// 32x16 PHY register file: read-only ID/status registers and reg0 bit15 soft reset.
module mdio_regfile
  import mdio_pkg::*;
#(
  parameter logic [15:0] PHY_ID1    = 16'h0022,
  parameter logic [15:0] PHY_ID2    = 16'h1619,
  parameter logic [15:0] STATUS_VAL = 16'h7809
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_data
);

  logic [15:0] mem [32];

  function automatic logic [15:0] reset_value(input logic [4:0] idx);
    case (idx)
      REG_STATUS: return STATUS_VAL;
      REG_ID1:    return PHY_ID1;
      REG_ID2:    return PHY_ID2;
      default:    return 16'h0000;
    endcase
  endfunction

  function automatic logic is_read_only(input logic [4:0] idx);
    return (idx == REG_STATUS) || (idx == REG_ID1) || (idx == REG_ID2);
  endfunction

  // NOTE: every entry has a defined reset value, so the array is reset explicitly;
  // this keeps it in flops rather than RAM, which is fine at 32 entries.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i[4:0]] <= reset_value(i[4:0]);
    end else if (wr_en) begin
      if (wr_addr == REG_CTRL && wr_data[SOFT_RESET_BIT]) begin
        for (int i = 0; i < 32; i++) mem[i[4:0]] <= reset_value(i[4:0]);
      end else if (!is_read_only(wr_addr)) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY responder: oversampled MDC/MDIO frame decoder driving a register file.
// Optional: define MDIO_PREAMBLE_SUPPRESS_EN to allow preamble suppression after a good frame.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter logic [15:0] PHY_ID1      = 16'h0022,
  parameter logic [15:0] PHY_ID2      = 16'h1619,
  parameter logic [15:0] STATUS_VAL   = 16'h7809,
  parameter int          PREAMBLE_LEN = 32
) (
  input logic                 clock,
  input logic                 reset,
  mdio_phy_responder_if.slave bus
);

  localparam int             PW       = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PW-1:0]  PRE_FULL = PW'(PREAMBLE_LEN);

  logic mdc_s1, mdc_s2, mdc_prev;
  logic mdio_s1, mdio_s2;
  logic mdc_rise, bit_in;

  // NOTE: all clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mdc_s1   <= 1'b0;
      mdc_s2   <= 1'b0;
      mdc_prev <= 1'b0;
      mdio_s1  <= 1'b0;
      mdio_s2  <= 1'b0;
    end else begin
      mdc_s1   <= bus.mdc;
      mdc_s2   <= mdc_s1;
      mdc_prev <= mdc_s2;
      mdio_s1  <= bus.mdio_i;
      mdio_s2  <= mdio_s1;
    end
  end

  assign mdc_rise = mdc_s2 & ~mdc_prev;
  assign bit_in   = mdio_s2;

  state_t        state;
  logic [PW-1:0] pre_cnt;
  logic [4:0]    bit_cnt;
  logic          op_msb;
  logic          is_read;
  logic [4:0]    phy_sr;
  logic [4:0]    reg_sr;
  logic [15:0]   rd_sr;
  logic [14:0]   wr_sr;

  logic [1:0]  op_now;
  logic [4:0]  reg_addr_now;
  logic [15:0] wr_word;
  logic [15:0] rd_data;
  logic        commit;
  logic        st_ok;

  assign op_now       = {op_msb, bit_in};
  assign reg_addr_now = {reg_sr[3:0], bit_in};
  assign wr_word      = {wr_sr, bit_in};
  assign commit       = mdc_rise && (state == WDATA) && (bit_cnt == 5'd15);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic suppress, frame_done, decode_err;

  // NOTE: defaults first so no path through the block leaves an output unassigned.
  always_comb begin
    frame_done = 1'b0;
    decode_err = 1'b0;
    if (mdc_rise) begin
      case (state)
        ST1:     decode_err = !bit_in;
        OP:      decode_err = (bit_cnt == 5'd1) && (op_now != OP_READ) && (op_now != OP_WRITE);
        RDATA:   frame_done = (bit_cnt == 5'd16);
        WDATA:   frame_done = (bit_cnt == 5'd15);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           suppress <= 1'b0;
    else if (decode_err) suppress <= 1'b0;
    else if (frame_done) suppress <= 1'b1;
  end

  assign st_ok = (pre_cnt == PRE_FULL) || suppress;
`else
  assign st_ok = (pre_cnt == PRE_FULL);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= PRE;
      pre_cnt          <= '0;
      bit_cnt          <= '0;
      op_msb           <= 1'b0;
      is_read          <= 1'b0;
      phy_sr           <= '0;
      reg_sr           <= '0;
      rd_sr            <= '0;
      wr_sr            <= '0;
      bus.mdio_o       <= 1'b0;
      bus.mdio_oe      <= 1'b0;
      bus.reg_wr_valid <= 1'b0;
      bus.reg_wr_addr  <= '0;
      bus.reg_wr_data  <= '0;
    end else begin
      bus.reg_wr_valid <= 1'b0;
      if (mdc_rise) begin
        bit_cnt <= bit_cnt + 5'd1;
        unique case (state)
          PRE: begin
            bit_cnt <= '0;
            if (bit_in) begin
              if (pre_cnt != PRE_FULL) pre_cnt <= pre_cnt + PW'(1);
            end else begin
              // Counter restarts whether or not ST is accepted, so each frame needs a fresh preamble.
              pre_cnt <= '0;
              if (st_ok) state <= ST1;
            end
          end
          ST1: begin
            bit_cnt <= '0;
            state   <= bit_in ? OP : PRE;
          end
          OP: begin
            op_msb <= bit_in;
            if (bit_cnt == 5'd1) begin
              bit_cnt <= '0;
              if (op_now == OP_READ || op_now == OP_WRITE) begin
                is_read <= (op_now == OP_READ);
                state   <= PHYAD;
              end else begin
                state <= PRE;
              end
            end
          end
          PHYAD: begin
            phy_sr <= {phy_sr[3:0], bit_in};
            if (bit_cnt == 5'd4) begin
              bit_cnt <= '0;
              state   <= REGAD;
            end
          end
          REGAD: begin
            reg_sr <= reg_addr_now;
            if (bit_cnt == 5'd4) begin
              bit_cnt <= '0;
              if (phy_sr != PHY_ADDR) begin
                state <= SKIP;
              end else begin
                // Read data is captured here so a later write cannot alter an in-flight read.
                rd_sr <= rd_data;
                state <= TA;
              end
            end
          end
          TA: begin
            if (is_read) begin
              bit_cnt     <= '0;
              bus.mdio_oe <= 1'b1;
              bus.mdio_o  <= 1'b0;
              state       <= RDATA;
            end else if (bit_cnt == 5'd1) begin
              bit_cnt <= '0;
              state   <= WDATA;
            end
          end
          RDATA: begin
            if (bit_cnt == 5'd16) begin
              bus.mdio_oe <= 1'b0;
              bus.mdio_o  <= 1'b0;
              state       <= PRE;
            end else begin
              bus.mdio_o <= rd_sr[15];
              rd_sr      <= {rd_sr[14:0], 1'b0};
            end
          end
          WDATA: begin
            wr_sr <= {wr_sr[13:0], bit_in};
            if (bit_cnt == 5'd15) begin
              bus.reg_wr_valid <= 1'b1;
              bus.reg_wr_addr  <= reg_sr;
              bus.reg_wr_data  <= wr_word;
              state            <= PRE;
            end
          end
          SKIP: begin
            if (bit_cnt == 5'd17) state <= PRE;
          end
          default: state <= PRE;
        endcase
      end
    end
  end

  mdio_regfile #(
    .PHY_ID1    (PHY_ID1),
    .PHY_ID2    (PHY_ID2),
    .STATUS_VAL (STATUS_VAL)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (commit),
    .wr_addr (reg_sr),
    .wr_data (wr_word),
    .rd_addr (reg_addr_now),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder acting as the MAC-side MDC/MDIO master.
module tb_mdio_phy_responder;

  logic clock;
  logic reset;
  logic mac_val;

  int n_checks;
  int n_fail;
  int oe_clks;
  int wr_pulses;
  logic [4:0]  last_wr_addr;
  logic [15:0] last_wr_data;

  mdio_phy_responder_if bus ();

  mdio_phy_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Open-drain style line: the PHY wins while enabled, otherwise the MAC (or pull-up) value.
  assign bus.mdio_i = bus.mdio_oe ? bus.mdio_o : mac_val;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.mdio_oe) oe_clks <= oe_clks + 1;
    if (bus.reg_wr_valid) begin
      wr_pulses    <= wr_pulses + 1;
      last_wr_addr <= bus.reg_wr_addr;
      last_wr_data <= bus.reg_wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One MDC period of 16 system clocks; the line is sampled just before the rising edge.
  task automatic mdc_cycle(input logic b, output logic line, output logic oe_seen);
    mac_val = b;
    repeat (8) @(negedge clock);
    line    = bus.mdio_i;
    oe_seen = bus.mdio_oe;
    bus.mdc = 1'b1;
    repeat (8) @(negedge clock);
    bus.mdc = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic l, o;
    for (int i = n - 1; i >= 0; i--) mdc_cycle(v[i], l, o);
  endtask

  task automatic send_header(input int pre, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] rg);
    for (int i = 0; i < pre; i++) send_bits(32'h1, 1);
    send_bits(32'h1, 2);
    send_bits({30'd0, op}, 2);
    send_bits({27'd0, phy}, 5);
    send_bits({27'd0, rg}, 5);
  endtask

  task automatic mdio_read(input int pre, input logic [4:0] phy, input logic [4:0] rg,
                           output logic [15:0] data, output logic ta1_oe, output logic ta2,
                           output int oe_n);
    logic l, o;
    int oe0;
    oe0  = oe_clks;
    data = '0;
    send_header(pre, 2'b10, phy, rg);
    for (int i = 0; i < 18; i++) begin
      mdc_cycle(1'b1, l, o);
      if (i == 0) ta1_oe = o;
      if (i == 1) ta2 = l;
      if (i >= 2) data = {data[14:0], l};
    end
    repeat (8) @(negedge clock);
    oe_n = oe_clks - oe0;
  endtask

  task automatic mdio_write(input int pre, input logic [4:0] phy, input logic [4:0] rg,
                            input logic [15:0] data, output int pulses);
    int p0;
    p0 = wr_pulses;
    send_header(pre, 2'b01, phy, rg);
    send_bits(32'h2, 2);
    send_bits({16'd0, data}, 16);
    repeat (8) @(negedge clock);
    pulses = wr_pulses - p0;
  endtask

  initial begin
    logic [15:0] d;
    logic        ta1_oe, ta2, l, o;
    int          oe_n, pulses, oe0;

    n_checks  = 0;
    n_fail    = 0;
    oe_clks   = 0;
    wr_pulses = 0;
    mac_val   = 1'b1;
    bus.mdc   = 1'b0;
    reset     = 1'b1;
    repeat (4) @(negedge clock);

    check("rst_oe", {31'd0, bus.mdio_oe}, 32'd0);
    check("rst_o", {31'd0, bus.mdio_o}, 32'd0);
    check("rst_wr_valid", {31'd0, bus.reg_wr_valid}, 32'd0);
    check("rst_wr_addr", {27'd0, bus.reg_wr_addr}, 32'd0);
    check("rst_wr_data", {16'd0, bus.reg_wr_data}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // 31-one preamble is one short: frame must be ignored.
    mdio_read(31, 5'd1, 5'd2, d, ta1_oe, ta2, oe_n);
    check("pre31_oe_clks", oe_n, 32'd0);

    mdio_read(32, 5'd1, 5'd2, d, ta1_oe, ta2, oe_n);
    check("rd_id1_data", {16'd0, d}, 32'h0022);
    check("rd_id1_ta1_oe", {31'd0, ta1_oe}, 32'd0);
    check("rd_id1_ta2", {31'd0, ta2}, 32'd0);
    check("rd_id1_oe_clks", oe_n, 32'd272);

    mdio_write(32, 5'd1, 5'd7, 16'hA5A5, pulses);
    check("wr7_pulses", pulses, 32'd1);
    check("wr7_addr", {27'd0, last_wr_addr}, 32'd7);
    check("wr7_data", {16'd0, last_wr_data}, 32'hA5A5);
    mdio_read(32, 5'd1, 5'd7, d, ta1_oe, ta2, oe_n);
    check("rd7_data", {16'd0, d}, 32'hA5A5);

    // Foreign PHY address: no drive, no write pulse.
    oe0 = wr_pulses;
    mdio_read(32, 5'd3, 5'd2, d, ta1_oe, ta2, oe_n);
    check("phy3_oe_clks", oe_n, 32'd0);
    check("phy3_pulses", wr_pulses - oe0, 32'd0);
    mdio_read(32, 5'd1, 5'd1, d, ta1_oe, ta2, oe_n);
    check("rd_status", {16'd0, d}, 32'h7809);

    mdio_write(32, 5'd1, 5'd7, 16'h1234, pulses);
    mdio_read(32, 5'd1, 5'd7, d, ta1_oe, ta2, oe_n);
    check("rd7_1234", {16'd0, d}, 32'h1234);
    mdio_write(32, 5'd1, 5'd0, 16'h8000, pulses);
    check("softrst_pulses", pulses, 32'd1);
    check("softrst_data", {16'd0, last_wr_data}, 32'h8000);
    mdio_read(32, 5'd1, 5'd7, d, ta1_oe, ta2, oe_n);
    check("rd7_after_softrst", {16'd0, d}, 32'h0000);
    mdio_read(32, 5'd1, 5'd0, d, ta1_oe, ta2, oe_n);
    check("rd0_after_softrst", {16'd0, d}, 32'h0000);

    mdio_write(32, 5'd1, 5'd3, 16'hFFFF, pulses);
    check("ro_wr_pulses", pulses, 32'd1);
    check("ro_wr_addr", {27'd0, last_wr_addr}, 32'd3);
    mdio_read(32, 5'd1, 5'd3, d, ta1_oe, ta2, oe_n);
    check("rd_id2_ro", {16'd0, d}, 32'h1619);

    // Reset while D8 of 0x0022 (a zero) is on the line.
    send_header(32, 2'b10, 5'd1, 5'd2);
    for (int i = 0; i < 9; i++) mdc_cycle(1'b1, l, o);
    check("mid_rd_oe", {31'd0, bus.mdio_oe}, 32'd1);
    check("mid_rd_d8", {31'd0, bus.mdio_o}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_oe", {31'd0, bus.mdio_oe}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    mdio_read(32, 5'd1, 5'd2, d, ta1_oe, ta2, oe_n);
    check("rd_after_rst", {16'd0, d}, 32'h0022);
    check("rd_after_rst_oe", oe_n, 32'd272);

    mdio_read(0, 5'd1, 5'd3, d, ta1_oe, ta2, oe_n);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    check("nopre_data", {16'd0, d}, 32'h1619);
    check("nopre_oe_clks", oe_n, 32'd272);
`else
    check("nopre_oe_clks", oe_n, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
